// File: rtl/shift_pkg.sv
// Shared definitions for the shift_arb slice: op codes, output-register
// state encoding and the round-robin search helper.
package shift_pkg;

  localparam logic [2:0] SH_SRL = 3'b001;
  localparam logic [2:0] SH_SRA = 3'b010;
  localparam logic [2:0] SH_SLL = 3'b100;

  // Largest requester count the search helper is written for.
  localparam int MAX_REQ = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Round-robin search: first valid requester at or after ptr, wrapping at
  // nreq. Returns {found, index}. The valid vector is zero-extended by the
  // caller to MAX_REQ bits; entries at or beyond nreq are never looked at.
  function automatic logic [3:0] rr_search(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
    logic       found;
    logic [2:0] win;
    int         idx;
    found = 1'b0;
    win   = 3'd0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        idx = int'(ptr) + k;
        if (idx >= nreq) begin
          idx = idx - nreq;
        end
        if (!found && valid[idx]) begin
          found = 1'b1;
          win   = 3'(idx);
        end
      end
    end
    return {found, win};
  endfunction

endpackage

// File: rtl/shift_arb_shift.sv
// Combinational 32-bit barrel shifter (SRL / SRA / SLL).
// Any code outside the three legal ones passes the operand through; the
// caller decides whether that is an error.
module shift
  import shift_pkg::*;
(
  input  logic [31:0] d,
  input  logic [4:0]  sa,
  input  logic [2:0]  c,
  output logic [31:0] res
);

  // Select the shift flavour from the one-hot op code.
  always_comb begin
    res = d;
    case (c)
      SH_SRL:  res = d >> sa;
      SH_SRA:  res = 32'($signed(d) >>> sa);
      SH_SLL:  res = d << sa;
      default: res = d;
    endcase
  end

endmodule

// File: rtl/shift_arb.sv
// shift_arb: round-robin arbiter sharing one barrel shifter between NREQ
// requesters, with a single output register (1-cycle latency, 1 op/cycle).
// Optional build macro SHIFT_ARB_ILLEGAL_CHK_EN: when defined, an op code
// outside {SRL, SRA, SLL} yields rsp_res=0 and rsp_err=1; when undefined the
// operand passes through and rsp_err stays 0.
// NREQ must be 2..8 and IDW must equal clog2(NREQ).
//
// state | meaning
// EMPTY | output register holds nothing, any request may be accepted
// FULL  | rsp_valid=1, result waits for rsp_ready
module shift_arb
  import shift_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_d,
  input  logic [5*NREQ-1:0] req_sa,
  input  logic [3*NREQ-1:0] req_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_res,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err
);

  state_e          state_q, state_d;
  logic [31:0]     res_q, res_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            err_q, err_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]      ptr_ext;
  logic [3:0]      search;
  logic            found;
  logic [IDW-1:0]  win_id;
  logic            can_acc;
  logic            acc;

  logic [31:0]     mux_d;
  logic [4:0]      mux_sa;
  logic [2:0]      mux_c;
  logic [31:0]     sh_res;
  logic [31:0]     op_res;
  logic            op_err;

  // Round-robin winner search starting at the pointer.
  always_comb begin
    valid_ext = MAX_REQ'(req_valid);
    ptr_ext   = 3'(rr_ptr_q);
    search    = rr_search(valid_ext, ptr_ext, NREQ);
    found     = search[3];
    win_id    = IDW'(search[2:0]);
  end

  // Accept when the output register is free or drains this cycle; nothing is
  // granted while reset is held so requesters never see a lost handshake.
  always_comb begin
    can_acc = (state_q == EMPTY) || rsp_ready;
    acc     = rst_n && can_acc && found;
  end

  // One-hot ready towards the winning requester only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = acc && (win_id == IDW'(i));
    end
  end

  // Steer the winner's payload into the shared shifter.
  always_comb begin
    mux_d  = '0;
    mux_sa = '0;
    mux_c  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        mux_d  = req_d[32*i +: 32];
        mux_sa = req_sa[5*i +: 5];
        mux_c  = req_c[3*i +: 3];
      end
    end
  end

  shift u_shift (
    .d   (mux_d),
    .sa  (mux_sa),
    .c   (mux_c),
    .res (sh_res)
  );

`ifdef SHIFT_ARB_ILLEGAL_CHK_EN
  // Illegal op codes are still accepted, but flagged and zeroed.
  always_comb begin
    op_err = !((mux_c == SH_SRL) || (mux_c == SH_SRA) || (mux_c == SH_SLL));
    op_res = op_err ? 32'd0 : sh_res;
  end
`else
  // Illegal op codes pass the operand through unflagged (shifter default).
  always_comb begin
    op_err = 1'b0;
    op_res = sh_res;
  end
`endif

  // Next-state for the output register, its payload and the rr pointer.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    id_d     = id_q;
    err_d    = err_q;
    rr_ptr_d = rr_ptr_q;
    if (acc) begin
      state_d  = FULL;
      res_d    = op_res;
      id_d     = win_id;
      err_d    = op_err;
      rr_ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Output register, state and pointer; reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      res_q    <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      id_q     <= id_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_res   = res_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb (NREQ=2) with a behavioural reference
// model of the arbiter, output register and shifter.
module tb_shift_arb;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_d = '0;
  logic [5*NREQ-1:0] req_sa = '0;
  logic [3*NREQ-1:0] req_c = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_res;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_full = 0;
  logic [31:0] m_res = '0;
  int          m_id = 0;
  logic        m_err = 1'b0;
  int          m_ptr = 0;

  shift_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_d     (req_d),
    .req_sa    (req_sa),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Bit-by-bit shift reference.
  function automatic void ref_shift(input logic [31:0] d, input logic [4:0] sa,
                                    input logic [2:0] c,
                                    output logic [31:0] r, output logic e);
    int s;
    s = int'(sa);
    r = d;
    e = 1'b0;
    if (c == 3'b001) begin
      for (int j = 0; j < 32; j++) r[j] = (j + s < 32) ? d[j+s] : 1'b0;
    end else if (c == 3'b010) begin
      for (int j = 0; j < 32; j++) r[j] = (j + s < 32) ? d[j+s] : d[31];
    end else if (c == 3'b100) begin
      for (int j = 0; j < 32; j++) r[j] = (j >= s) ? d[j-s] : 1'b0;
    end else begin
`ifdef SHIFT_ARB_ILLEGAL_CHK_EN
      r = 32'd0;
      e = 1'b1;
`else
      r = d;
      e = 1'b0;
`endif
    end
  endfunction

  function automatic int ref_winner(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] ref_ready();
    int w;
    w = ref_winner(req_valid, m_ptr);
    if ((!m_full || rsp_ready) && w >= 0) return NREQ'(1) << w;
    return '0;
  endfunction

  task automatic drive(input logic [1:0] v,
                       input logic [31:0] d0, input logic [4:0] sa0, input logic [2:0] c0,
                       input logic [31:0] d1, input logic [4:0] sa1, input logic [2:0] c1,
                       input logic rr);
    req_valid = v;
    req_d     = {d1, d0};
    req_sa    = {sa1, sa0};
    req_c     = {c1, c0};
    rsp_ready = rr;
  endtask

  function automatic logic [2:0] rand_code();
    int k;
    k = $urandom_range(0, 7);
    if (k < 2) return 3'b001;
    if (k < 4) return 3'b010;
    if (k < 6) return 3'b100;
    return 3'($urandom);
  endfunction

  // Samples inputs before the edge, updates the model after it, returns on
  // the following falling edge.
  task automatic advance();
    bit          can;
    int          w;
    logic [31:0] r;
    logic        e;
    can = !m_full || rsp_ready;
    w   = ref_winner(req_valid, m_ptr);
    r   = '0;
    e   = 1'b0;
    if (can && w >= 0) ref_shift(req_d[32*w +: 32], req_sa[5*w +: 5], req_c[3*w +: 3], r, e);
    @(posedge clk);
    if (can && w >= 0) begin
      m_full = 1;
      m_res  = r;
      m_err  = e;
      m_id   = w;
      m_ptr  = (w + 1) % NREQ;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    advance();
  endtask

  task automatic test_reset();
    drive(2'b11, 32'hFFFF_FFFF, 5'd3, 3'b001, 32'h1, 5'd1, 3'b100, 1'b1);
    #3;
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rsp_valid); end
    checks++;
    if (rsp_res !== 32'd0) begin failures++; $display("FAIL reset_res got=%h exp=0", rsp_res); end
    checks++;
    if (rsp_id !== '0) begin failures++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++;
    if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", rsp_err); end
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    @(negedge clk);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    rst_n = 1'b1;
    m_full = 0;
    m_ptr  = 0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    drive(2'b01, 32'h8000_0001, 5'd1, 3'b001, 32'h0, 5'd0, 3'b000, 1'b1);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL dir1_ready got=%b exp=01", req_ready); end
    advance();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 32'h4000_0000 || rsp_id !== 1'b0)
      begin failures++; $display("FAIL dir1_rsp got=v%0b %h id%0d exp=v1 40000000 id0", rsp_valid, rsp_res, rsp_id); end

    drive(2'b10, 32'h0, 5'd0, 3'b001, 32'h8000_0000, 5'd4, 3'b010, 1'b1);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL dir2_ready got=%b exp=10", req_ready); end
    advance();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 32'hF800_0000 || rsp_id !== 1'b1)
      begin failures++; $display("FAIL dir2_sra got=v%0b %h id%0d exp=v1 f8000000 id1", rsp_valid, rsp_res, rsp_id); end

    drive(2'b10, 32'h0, 5'd0, 3'b001, 32'h1, 5'd31, 3'b100, 1'b1);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL dir3_ready got=%b exp=10", req_ready); end
    advance();
    checks++;
    if (rsp_res !== 32'h8000_0000 || rsp_id !== 1'b1)
      begin failures++; $display("FAIL dir3_sll got=%h id%0d exp=80000000 id1", rsp_res, rsp_id); end

    drain();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL dir_drain got=%0b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int          g;
    logic [31:0] d0, d1, er;
    logic [4:0]  s0, s1;
    logic [2:0]  c0, c1;
    logic        ee;
    g = m_ptr;
    for (int n = 0; n < 8; n++) begin
      d0 = $urandom; d1 = $urandom; s0 = 5'($urandom); s1 = 5'($urandom);
      c0 = 3'b001 << $urandom_range(0, 2);
      c1 = 3'b001 << $urandom_range(0, 2);
      drive(2'b11, d0, s0, c0, d1, s1, c1, 1'b1);
      #1;
      checks++;
      if (req_ready !== (2'b01 << g)) begin failures++; $display("FAIL b2b_ready n=%0d got=%b exp_grant=%0d", n, req_ready, g); end
      if (g == 0) ref_shift(d0, s0, c0, er, ee);
      else ref_shift(d1, s1, c1, er, ee);
      advance();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_res !== er || rsp_id !== IDW'(g))
        begin failures++; $display("FAIL b2b_rsp n=%0d got=v%0b %h id%0d exp=v1 %h id%0d", n, rsp_valid, rsp_res, rsp_id, er, g); end
      g = 1 - g;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_res;
    int          hold_id;
    drive(2'b01, 32'hDEAD_BEEF, 5'd8, 3'b001, 32'h0, 5'd0, 3'b001, 1'b1);
    advance();
    hold_res = m_res;
    hold_id  = m_id;
    checks++;
    if (rsp_res !== 32'h00DE_ADBE) begin failures++; $display("FAIL bp_load got=%h exp=00deadbe", rsp_res); end
    for (int n = 0; n < 5; n++) begin
      drive(2'b11, $urandom, 5'($urandom), 3'b100, $urandom, 5'($urandom), 3'b010, 1'b0);
      #1;
      checks++;
      if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_ready n=%0d got=%b exp=00", n, req_ready); end
      advance();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_res !== hold_res || rsp_id !== IDW'(hold_id))
        begin failures++; $display("FAIL bp_hold n=%0d got=v%0b %h id%0d exp=v1 %h id%0d", n, rsp_valid, rsp_res, rsp_id, hold_res, hold_id); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_release_ready got=%b exp=10", req_ready); end
    advance();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== m_res || rsp_id !== 1'b1)
      begin failures++; $display("FAIL bp_release_rsp got=v%0b %h id%0d exp=v1 %h id1", rsp_valid, rsp_res, rsp_id, m_res); end
    drain();
  endtask

  task automatic test_illegal();
    drive(2'b01, 32'h1234_5678, 5'd7, 3'b011, 32'h0, 5'd0, 3'b001, 1'b1);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL ill_ready got=%b exp=01", req_ready); end
    advance();
`ifdef SHIFT_ARB_ILLEGAL_CHK_EN
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 32'd0 || rsp_err !== 1'b1)
      begin failures++; $display("FAIL ill_rsp got=v%0b %h err%0b exp=v1 0 err1", rsp_valid, rsp_res, rsp_err); end
`else
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 32'h1234_5678 || rsp_err !== 1'b0)
      begin failures++; $display("FAIL ill_rsp got=v%0b %h err%0b exp=v1 12345678 err0", rsp_valid, rsp_res, rsp_err); end
`endif
    drain();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] er;
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom), $urandom, 5'($urandom), rand_code(),
            $urandom, 5'($urandom), rand_code(), ($urandom_range(0, 9) < 7));
      #1;
      er = ref_ready();
      checks++;
      if (req_ready !== er) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, er); end
      advance();
      checks++;
      if (rsp_valid !== m_full) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, rsp_valid, m_full); end
      if (m_full) begin
        checks++;
        if (rsp_res !== m_res || rsp_id !== IDW'(m_id) || rsp_err !== m_err)
          begin failures++; $display("FAIL rnd_rsp n=%0d got=%h id%0d err%0b exp=%h id%0d err%0b", n, rsp_res, rsp_id, rsp_err, m_res, m_id, m_err); end
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    drive(2'b01, 32'hCAFE_F00D, 5'd0, 3'b010, 32'h0, 5'd0, 3'b001, 1'b1);
    advance();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_res !== 32'hCAFE_F00D)
      begin failures++; $display("FAIL ar_pre got=v%0b %h exp=v1 cafef00d", rsp_valid, rsp_res); end
    drive(2'b11, 32'h5, 5'd1, 3'b100, 32'h7, 5'd2, 3'b100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%0b exp=0", rsp_valid); end
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL ar_ready got=%b exp=00", req_ready); end
    m_full = 0;
    m_ptr  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL ar_first_grant got=%b exp=01", req_ready); end
    advance();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 32'hA)
      begin failures++; $display("FAIL ar_first_rsp got=v%0b %h id%0d exp=v1 0000000a id0", rsp_valid, rsp_res, rsp_id); end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
